// File: rtl/init_arb_pkg.sv
// Shared types and helpers for the multi-channel init-request ingress.
// Falls back to local widths when the datatypes header has not defined them.
`ifndef RID_WIDTH
`define RID_WIDTH 8
`endif
`ifndef INIT_REQ_WIDTH
`define INIT_REQ_WIDTH 256
`endif

package init_arb_pkg;

    localparam int unsigned RidWidthDef     = `RID_WIDTH;
    localparam int unsigned InitReqWidthDef = `INIT_REQ_WIDTH;

    // Channel-index width; a single channel still gets one bit of RID space.
    function automatic int unsigned ch_bits(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic [InitReqWidthDef-1:0] payload;
        logic [RidWidthDef-1:0]     rid;
    } init_req_t;

endpackage

// File: rtl/init_arb_fifo.sv
// Circular-buffer sync FIFO with occupancy count; head reads as zero when empty.
module init_arb_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned OccW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            arst,
    input  logic            push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic            pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic            full,
    output logic            empty,
    output logic [OccW-1:0] occupancy
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_q, rd_q;
    logic [OccW-1:0]  occ_q, occ_d;
    logic             do_push, do_pop;

    assign full    = (occ_q == OccW'(DEPTH));
    assign empty   = (occ_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        occ_d = occ_q;
        unique case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + OccW'(1);
            2'b01:   occ_d = occ_q - OccW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PtrW'(1);
            if (do_pop)  rd_q <= rd_q + PtrW'(1);
            occ_q <= occ_d;
        end
    end

    // Storage is not reset; the empty gate keeps stale entries off the output.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_dat;
    end

    assign pop_dat   = empty ? '0 : mem_q[rd_q];
    assign occupancy = occ_q;

endmodule

// File: rtl/init_arb.sv
// Round-robin ingress for NUM_CH init-request streams into one queued output stream.
// Define INIT_ARB_RID_STAMP_EN to overwrite RID with {channel, per-channel sequence}.
module init_arb
    import init_arb_pkg::*;
#(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned PAYLOAD_WIDTH = 256,
    parameter int unsigned RID_WIDTH     = RidWidthDef,
    localparam int unsigned DatW   = PAYLOAD_WIDTH + RID_WIDTH,
    localparam int unsigned ChBits = ch_bits(NUM_CH),
    localparam int unsigned OccW   = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic [NUM_CH*DatW-1:0] in_dat,
    input  logic [NUM_CH-1:0]      in_vld,
    output logic [NUM_CH-1:0]      in_rdy,
    output logic [DatW-1:0]        out_dat,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic [OccW-1:0]        occupancy
);

    logic [ChBits-1:0] rr_q, rr_d, sel;
    logic              any_vld, full, empty, xfer;
    logic [DatW-1:0]   sel_dat, push_dat;

    // First valid channel at or after rr_q, wrapping modulo NUM_CH.
    always_comb begin
        int idx;
        idx     = 0;
        sel     = '0;
        any_vld = 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            idx = int'(rr_q) + i;
            if (idx >= int'(NUM_CH)) idx = idx - int'(NUM_CH);
            if (!any_vld && in_vld[ChBits'(idx)]) begin
                any_vld = 1'b1;
                sel     = ChBits'(idx);
            end
        end
    end

    always_comb begin
        in_rdy = '0;
        if (any_vld && !full && !arst) in_rdy[sel] = 1'b1;
    end

    assign xfer = |(in_vld & in_rdy);

    always_comb begin
        sel_dat = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (ChBits'(c) == sel) sel_dat = in_dat[c*DatW +: DatW];
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (xfer) rr_d = (int'(sel) + 1 >= int'(NUM_CH)) ? '0 : sel + ChBits'(1);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) rr_q <= '0;
        else      rr_q <= rr_d;
    end

`ifdef INIT_ARB_RID_STAMP_EN
    localparam int unsigned SeqW = RID_WIDTH - ChBits;

    logic [SeqW-1:0]      seq_q [NUM_CH];
    logic [RID_WIDTH-1:0] unused_in_rid;

    assign unused_in_rid = sel_dat[RID_WIDTH-1:0];
    assign push_dat      = {sel_dat[DatW-1:RID_WIDTH], sel, seq_q[sel]};

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int c = 0; c < int'(NUM_CH); c++) seq_q[c] <= '0;
        end else if (xfer) begin
            seq_q[sel] <= seq_q[sel] + SeqW'(1);
        end
    end
`else
    assign push_dat = sel_dat;
`endif

    init_arb_fifo #(
        .WIDTH (DatW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .arst      (arst),
        .push      (xfer),
        .push_dat  (push_dat),
        .pop       (out_rdy),
        .pop_dat   (out_dat),
        .full      (full),
        .empty     (empty),
        .occupancy (occupancy)
    );

    assign out_vld = ~empty;

endmodule

// File: doc/init_arb.md
# init_arb

Multi-channel ingress for the ray-initialisation stage. Accepts `NUM_CH` independent init-request streams, arbitrates round-robin, optionally stamps a request ID (channel + per-channel sequence) into the RID field, and buffers accepted requests in a `FIFO_DEPTH`-entry queue that drives the single `init` request stream. It sits between the ray generators and `init`, replacing the single-source hookup.

## Interface
- `NUM_CH`, 4: number of input channels, 1..16.
- `FIFO_DEPTH`, 4: output queue entries, power of two, ≥2.
- `PAYLOAD_WIDTH`, 256: request payload bits (8×32), excluding RID.
- `RID_WIDTH`, `` `RID_WIDTH ``: RID field width. Must satisfy RID_WIDTH > CH_BITS, where CH_BITS = max(1, clog2(NUM_CH)).
- `clk`  in  1  single clock, all state on rising edge.
- `arst`  in  1  asynchronous, active-high reset.
- `in_dat`  in  NUM_CH×(PAYLOAD_WIDTH+RID_WIDTH)  channel c occupies slice c; layout {payload, rid}, RID in the LSBs.
- `in_vld`  in  NUM_CH  per-channel valid.
- `in_rdy`  out  NUM_CH  per-channel ready; at most one bit high per cycle.
- `out_dat`  out  PAYLOAD_WIDTH+RID_WIDTH  head of queue, same {payload, rid} layout; feeds `init_req_stream_rsc_dat`.
- `out_vld`  out  1  queue non-empty.
- `out_rdy`  in  1  downstream ready.
- `occupancy`  out  clog2(FIFO_DEPTH+1)  entries currently held.

## Operation
- Arbitration is combinational each cycle. Search in_vld starting at `rr_ptr`, wrapping modulo NUM_CH. The first valid channel is `sel`.
- `in_rdy[sel]` = !full. All other in_rdy bits = 0. When no channel is valid, in_rdy is all-zero.
- Transfer on a channel happens when in_vld & in_rdy. On transfer:
  - push {payload, rid'} into the queue;
  - rr_ptr ← (sel+1) mod NUM_CH.
- rr_ptr holds when no transfer occurs. A channel that asserts in_vld is granted within NUM_CH accepted transfers (no starvation).
- in_rdy does not depend on out_rdy. When full, no push occurs even if a pop happens in the same cycle.
- Pop happens when out_vld & out_rdy. Push and pop in the same cycle leave occupancy unchanged.
- Queue is a circular buffer:
  - wr_ptr/rd_ptr are clog2(FIFO_DEPTH) bits and wrap naturally;
  - full/empty are derived from `occupancy` (== FIFO_DEPTH / == 0).
- Handshake rules:
  - out_dat is stable while out_vld & !out_rdy.
  - Inputs may drop in_vld without a transfer; no state changes in that case.

## Timing
- Reset (arst high, async): rr_ptr = 0, wr_ptr = rd_ptr = 0, occupancy = 0, out_vld = 0, out_dat = 0, all seq counters = 0. in_rdy is forced to 0 while arst is high.
- Latency: a request accepted at edge N appears on out_dat with out_vld = 1 after edge N (visible in cycle N+1), provided the queue was empty.
- Throughput: one push and one pop per cycle sustained.
- Full boundary:
  - with occupancy = FIFO_DEPTH, all in_rdy = 0 that cycle;
  - a pop at edge N re-opens in_rdy in cycle N+1.
- Reset mid-transfer: queued contents are discarded and no partial output is emitted. After deassertion, the first transfer comes from the lowest-index valid channel.

## Configuration
- `INIT_ARB_RID_STAMP_EN` defined:
  - rid' = {sel[CH_BITS-1:0], seq[sel]}, with seq[c] of width RID_WIDTH−CH_BITS;
  - seq[sel] increments on each transfer from that channel and wraps to 0 after 2^(RID_WIDTH−CH_BITS)−1.
- Not defined: rid' = the input RID unchanged, and no seq counters are instantiated.

## Structure
- Shared package `init_arb_pkg`:
  - CH_BITS computation function;
  - typedef `init_req_t` (payload + rid packed struct) built from the existing `` `INIT_REQ_WIDTH ``/`` `RID_WIDTH `` macros in the datatypes header.
- One sub-module, `init_arb_fifo`: parametrised width/depth sync FIFO with occupancy output. Arbiter and RID stamping stay in the top.

## Test plan
- Single channel: NUM_CH=4, only ch2 valid with 10 requests, out_rdy=1 → 10 outputs in order, 1 per cycle, first out_vld one cycle after first accept. With STAMP_EN, RIDs are {2,0}..{2,9}.
- Fairness: all 4 channels always valid, out_rdy=1, 16 transfers → grant order 0,1,2,3 repeated 4×, each channel accepted exactly 4 times.
- Backpressure: out_rdy=0, FIFO_DEPTH=4, ch0 valid → exactly 4 accepts, then in_rdy=0 and occupancy=4. Raise out_rdy for one cycle → in_rdy[0] high the next cycle, occupancy returns to 4.
- Simultaneous push/pop: occupancy=2, one accept and one pop in the same cycle → occupancy stays 2 and data order is preserved.
- Sequence wrap (STAMP_EN, RID_WIDTH=4, NUM_CH=4): 5 requests on ch1 → RIDs 0x4,0x5,0x6,0x7,0x4. Without the macro, the input RID 0xA passes through unchanged.
- Mid-stream reset: assert arst with occupancy=3 → out_vld=0, occupancy=0 immediately. After release with ch3 and ch1 valid, ch1 is granted first.
